// File: rtl/gray_seq_checker.sv
// Gray-code sequence checker: registers the binary value of each accepted sample and checks
// +1 steps. Define GRAY_CHK_STALL_EN to add stall detection and the stall output.
module gray_seq_checker #(
    parameter int unsigned WIDTH     = 4,
    parameter int unsigned LOCK_RUN  = 2,
    parameter int unsigned ERR_CNT_W = 8,
    parameter int unsigned STALL_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [WIDTH-1:0]     gray_in,
    input  logic                 clear_err,
    output logic [WIDTH-1:0]     bin_out,
    output logic                 locked,
    output logic                 step_err,
    output logic                 wrap,
`ifdef GRAY_CHK_STALL_EN
    output logic                 stall,
`endif
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic [0:0] {StUnlocked, StLocked} state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     prev_q, prev_d;
    logic                 have_prev_q, have_prev_d;
    logic [3:0]           run_q, run_d;
    logic                 step_err_q, step_err_d;
    logic                 wrap_q, wrap_d;
    logic [ERR_CNT_W-1:0] err_q, err_d;
    logic [WIDTH-1:0]     bin_in;
    logic                 good_step;
    logic                 hold_sample;

    always_comb begin
        bin_in = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            bin_in[i] = ^(gray_in >> i);
        end
    end

    assign good_step = have_prev_q && (bin_in == prev_q + WIDTH'(1));

`ifdef GRAY_CHK_STALL_EN
    localparam int unsigned StallW = $clog2(STALL_MAX + 1);

    logic              stall_q, stall_d;
    logic [StallW-1:0] stall_cnt_q, stall_cnt_d;

    // A repeated sample is neutral: it neither advances nor breaks the run.
    assign hold_sample = have_prev_q && (bin_in == prev_q);
    assign stall       = stall_q;
`else
    assign hold_sample = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        prev_d      = prev_q;
        have_prev_d = have_prev_q;
        run_d       = run_q;
        step_err_d  = 1'b0;
        wrap_d      = 1'b0;
        err_d       = err_q;
`ifdef GRAY_CHK_STALL_EN
        stall_d     = stall_q;
        stall_cnt_d = stall_cnt_q;
`endif
        if (en) begin
            prev_d      = bin_in;
            have_prev_d = 1'b1;
`ifdef GRAY_CHK_STALL_EN
            if (!hold_sample) stall_cnt_d = '0;
            if (good_step)    stall_d     = 1'b0;
`endif
            if (!have_prev_q) begin
                // First sample after reset only seeds prev.
            end else if (good_step) begin
                if (state_q == StUnlocked) begin
                    if (run_q + 4'd1 == 4'(LOCK_RUN)) begin
                        state_d = StLocked;
                        run_d   = '0;
                    end else begin
                        run_d = run_q + 4'd1;
                    end
                end else begin
                    wrap_d = (prev_q == {WIDTH{1'b1}}) && (bin_in == '0);
                end
            end else if (hold_sample) begin
`ifdef GRAY_CHK_STALL_EN
                if (stall_cnt_q != StallW'(STALL_MAX)) stall_cnt_d = stall_cnt_q + StallW'(1);
                if (stall_cnt_q + StallW'(1) >= StallW'(STALL_MAX)) stall_d = 1'b1;
`endif
            end else begin
                run_d = '0;
                if (state_q == StLocked) begin
                    step_err_d = 1'b1;
                    state_d    = StUnlocked;
                    if (err_q != {ERR_CNT_W{1'b1}}) err_d = err_q + ERR_CNT_W'(1);
                end
            end
        end
        if (clear_err) err_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StUnlocked;
            prev_q      <= '0;
            have_prev_q <= 1'b0;
            run_q       <= '0;
            step_err_q  <= 1'b0;
            wrap_q      <= 1'b0;
            err_q       <= '0;
`ifdef GRAY_CHK_STALL_EN
            stall_q     <= 1'b0;
            stall_cnt_q <= '0;
`endif
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            have_prev_q <= have_prev_d;
            run_q       <= run_d;
            step_err_q  <= step_err_d;
            wrap_q      <= wrap_d;
            err_q       <= err_d;
`ifdef GRAY_CHK_STALL_EN
            stall_q     <= stall_d;
            stall_cnt_q <= stall_cnt_d;
`endif
        end
    end

    assign bin_out   = prev_q;
    assign locked    = (state_q == StLocked);
    assign step_err  = step_err_q;
    assign wrap      = wrap_q;
    assign err_count = err_q;

endmodule

// File: tb/tb_gray_seq_checker.sv
// Directed, table-driven bench for gray_seq_checker with default parameters.
module tb_gray_seq_checker;

    logic       clk = 1'b0;
    logic       rst, en, clear_err;
    logic [3:0] gray_in;
    logic [3:0] bin_out;
    logic       locked, step_err, wrap;
    logic [7:0] err_count;
`ifdef GRAY_CHK_STALL_EN
    logic       stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gray_seq_checker dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .gray_in   (gray_in),
        .clear_err (clear_err),
        .bin_out   (bin_out),
        .locked    (locked),
        .step_err  (step_err),
        .wrap      (wrap),
`ifdef GRAY_CHK_STALL_EN
        .stall     (stall),
`endif
        .err_count (err_count)
    );

    typedef struct {
        logic       r, e, c;
        logic [3:0] g;
        logic [3:0] b;
        logic       lk, se, wr;
        logic [7:0] ec;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic e, input logic c, input logic [3:0] g,
                       input logic [3:0] b, input logic lk, input logic se, input logic wr,
                       input logic [7:0] ec);
        vec_t v;
        v.r = r; v.e = e; v.c = c; v.g = g; v.b = b;
        v.lk = lk; v.se = se; v.wr = wr; v.ec = ec;
        tbl.push_back(v);
    endtask

    task automatic apply(input logic r, input logic e, input logic c, input logic [3:0] g);
        rst = r; en = e; clear_err = c; gray_in = g;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    initial begin
        logic [3:0] cur;
        int         n;

        rst = 1'b1; en = 1'b0; clear_err = 1'b0; gray_in = '0;

        // rst en clr gray | bin lk se wr ec
        add(1, 1, 0, 4'h5,  0, 0, 0, 0, 0);
        add(0, 1, 0, 4'h0,  0, 0, 0, 0, 0);
        add(0, 1, 0, 4'h1,  1, 0, 0, 0, 0);
        add(0, 1, 0, 4'h3,  2, 1, 0, 0, 0);
        add(0, 1, 0, 4'h2,  3, 1, 0, 0, 0);
        add(0, 1, 0, 4'h6,  4, 1, 0, 0, 0);
        add(0, 1, 0, 4'h7,  5, 1, 0, 0, 0);
        add(0, 1, 0, 4'h5,  6, 1, 0, 0, 0);
        add(0, 1, 0, 4'h4,  7, 1, 0, 0, 0);
        add(0, 1, 0, 4'hC,  8, 1, 0, 0, 0);
        add(0, 1, 0, 4'hD,  9, 1, 0, 0, 0);
        add(0, 1, 0, 4'hF, 10, 1, 0, 0, 0);
        add(0, 1, 0, 4'hE, 11, 1, 0, 0, 0);
        add(0, 1, 0, 4'hA, 12, 1, 0, 0, 0);
        add(0, 1, 0, 4'hB, 13, 1, 0, 0, 0);
        add(0, 1, 0, 4'h9, 14, 1, 0, 0, 0);
        add(0, 1, 0, 4'h8, 15, 1, 0, 0, 0);
        add(0, 1, 0, 4'h0,  0, 1, 0, 1, 0);
        add(0, 1, 0, 4'h1,  1, 1, 0, 0, 0);
        add(0, 1, 0, 4'h3,  2, 1, 0, 0, 0);
        add(0, 1, 0, 4'h2,  3, 1, 0, 0, 0);
        add(0, 1, 0, 4'h6,  4, 1, 0, 0, 0);
        add(0, 1, 0, 4'hF, 10, 0, 1, 0, 1);
        add(0, 1, 0, 4'hE, 11, 0, 0, 0, 1);
        add(0, 1, 0, 4'hA, 12, 1, 0, 0, 1);
        add(0, 1, 0, 4'hB, 13, 1, 0, 0, 1);
        // en low: random-looking input must be ignored
        add(0, 0, 0, 4'h7, 13, 1, 0, 0, 1);
        add(0, 0, 0, 4'hF, 13, 1, 0, 0, 1);
        add(0, 0, 0, 4'h2, 13, 1, 0, 0, 1);
        add(0, 0, 0, 4'h9, 13, 1, 0, 0, 1);
        add(0, 0, 0, 4'h0, 13, 1, 0, 0, 1);
        add(0, 0, 0, 4'hC, 13, 1, 0, 0, 1);
        add(0, 0, 0, 4'h5, 13, 1, 0, 0, 1);
        add(0, 0, 0, 4'hE, 13, 1, 0, 0, 1);
        add(0, 0, 0, 4'h3, 13, 1, 0, 0, 1);
        add(0, 0, 0, 4'h8, 13, 1, 0, 0, 1);
        add(0, 1, 0, 4'h9, 14, 1, 0, 0, 1);
        add(0, 1, 0, 4'h8, 15, 1, 0, 0, 1);
        add(0, 1, 0, 4'h0,  0, 1, 0, 1, 1);
        add(0, 1, 1, 4'h1,  1, 1, 0, 0, 0);
        add(1, 1, 0, 4'h3,  0, 0, 0, 0, 0);
        add(0, 1, 0, 4'h0,  0, 0, 0, 0, 0);
        add(0, 1, 0, 4'h7,  5, 0, 0, 0, 0);
        add(0, 1, 0, 4'h5,  6, 0, 0, 0, 0);
        add(0, 1, 0, 4'h4,  7, 1, 0, 0, 0);
`ifndef GRAY_CHK_STALL_EN
        add(0, 1, 0, 4'h4,  7, 0, 1, 0, 1);
`endif

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].e, tbl[i].c, tbl[i].g);
            chk($sformatf("v%0d.bin_out", i), int'(bin_out), int'(tbl[i].b));
            chk($sformatf("v%0d.locked", i), int'(locked), int'(tbl[i].lk));
            chk($sformatf("v%0d.step_err", i), int'(step_err), int'(tbl[i].se));
            chk($sformatf("v%0d.wrap", i), int'(wrap), int'(tbl[i].wr));
            chk($sformatf("v%0d.err_count", i), int'(err_count), int'(tbl[i].ec));
        end

        // Saturation: relock twice, then break lock, 300 times.
        apply(1, 0, 0, 4'h0);
        cur = 4'd0;
        n = 0;
        apply(0, 1, 0, to_gray(cur));
        for (int i = 0; i < 300; i++) begin
            cur = cur + 4'd1; apply(0, 1, 0, to_gray(cur));
            cur = cur + 4'd1; apply(0, 1, 0, to_gray(cur));
            chk("sat.relock", int'(locked), 1);
            cur = cur + 4'd5; apply(0, 1, 0, to_gray(cur));
            if (n < 255) n++;
            chk("sat.step_err", int'(step_err), 1);
            chk("sat.err_count", int'(err_count), n);
        end
        chk("sat.final", int'(err_count), 255);
        cur = cur + 4'd1; apply(0, 1, 0, to_gray(cur));
        cur = cur + 4'd1; apply(0, 1, 0, to_gray(cur));
        cur = cur + 4'd7; apply(0, 1, 1, to_gray(cur));
        chk("clr_vs_inc.step_err", int'(step_err), 1);
        chk("clr_vs_inc.err_count", int'(err_count), 0);
        cur = cur + 4'd1; apply(0, 1, 0, to_gray(cur));
        chk("after_clr.err_count", int'(err_count), 0);
        chk("after_clr.step_err", int'(step_err), 0);

`ifdef GRAY_CHK_STALL_EN
        apply(1, 0, 0, 4'h0);
        apply(0, 1, 0, 4'h3);
        for (int i = 1; i <= 4; i++) begin
            apply(0, 1, 0, 4'h3);
            chk($sformatf("stall.rep%0d", i), int'(stall), (i == 4) ? 1 : 0);
            chk($sformatf("stall.err%0d", i), int'(step_err) + int'(err_count), 0);
        end
        apply(0, 1, 0, 4'h2);
        chk("stall.clear", int'(stall), 0);
        chk("stall.bin", int'(bin_out), 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
